store_queue: RTL

Circular store queue downstream of the store address stage. Entries are allocated in program order at dispatch, filled with address, shifted data and byte mask when the store address stage resolves them, marked committed at retirement, and drained in order to data memory through a valid/ready port. It also exports the mask of allocated-but-unresolved stores, so load issue can hold loads behind unknown store addresses.

---
 rtl/store_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/store_queue.sv
// Circular store queue: in-order allocate at dispatch, out-of-order address resolve,
// in-order retire, and in-order drain to data memory over a valid/ready port.
module store_queue #(
  parameter int SQ_SZ = 8,
  localparam int PW = $clog2(SQ_SZ),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_ok,
  output logic [SQ_SZ-1:0] alloc_mask,
  input  logic             resolve_valid,
  input  logic [SQ_SZ-1:0] resolve_mask,
  input  logic [31:0]      resolve_addr,
  input  logic [31:0]      resolve_data,
  input  logic [3:0]       resolve_byte_mask,
  input  logic             retire_valid,
  input  logic             squash,
  output logic             mem_req_valid,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_data,
  output logic [3:0]       mem_req_byte_mask,
  input  logic             mem_req_ready,
  output logic [SQ_SZ-1:0] unresolved_mask,
  output logic             empty,
  output logic [CW-1:0]    count
);

  typedef enum logic [1:0] {S_FREE, S_ALLOC, S_RESOLVED, S_RETIRED} sq_state_e;

  sq_state_e   st_q   [SQ_SZ];
  sq_state_e   st_d   [SQ_SZ];
  logic [31:0] addr_q [SQ_SZ];
  logic [31:0] addr_d [SQ_SZ];
  logic [31:0] data_q [SQ_SZ];
  logic [31:0] data_d [SQ_SZ];
  logic [3:0]  bm_q   [SQ_SZ];
  logic [3:0]  bm_d   [SQ_SZ];
  logic [PW-1:0] head_q, head_d, ret_q, ret_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, n_ret;
  logic drain_go, retire_go, alloc_go;

  // Handshake: a memory transfer happens on a rising edge where mem_req_valid
  // and mem_req_ready are both high; valid never drops before that transfer.
  assign mem_req_valid = (st_q[head_q] == S_RETIRED);
  assign mem_req_addr      = mem_req_valid ? addr_q[head_q] : 32'd0;
  assign mem_req_data      = mem_req_valid ? data_q[head_q] : 32'd0;
  assign mem_req_byte_mask = mem_req_valid ? bm_q[head_q]   : 4'd0;
  assign alloc_ok   = (count_q != CW'(SQ_SZ));
  assign alloc_mask = SQ_SZ'(1) << tail_q;
  assign empty      = (count_q == '0);
  assign count      = count_q;

  always_comb begin
    unresolved_mask = '0;
    for (int i = 0; i < SQ_SZ; i++) unresolved_mask[i] = (st_q[i] == S_ALLOC);
  end

  always_comb begin
    for (int i = 0; i < SQ_SZ; i++) begin
      st_d[i]   = st_q[i];
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      bm_d[i]   = bm_q[i];
    end
    head_d    = head_q;
    ret_d     = ret_q;
    tail_d    = tail_q;
    n_ret     = '0;
    drain_go  = mem_req_valid && mem_req_ready;
    retire_go = retire_valid && (st_q[ret_q] == S_RESOLVED);
    alloc_go  = alloc_req && alloc_ok && !squash;

    for (int i = 0; i < SQ_SZ; i++) begin
      if (resolve_valid && resolve_mask[i] && (st_q[i] == S_ALLOC) && !squash) begin
        st_d[i]   = S_RESOLVED;
        addr_d[i] = resolve_addr;
        data_d[i] = resolve_data;
        bm_d[i]   = resolve_byte_mask;
      end
    end

    // Retire is applied before squash so the entry retiring this cycle survives.
    if (retire_go) begin
      st_d[ret_q] = S_RETIRED;
      ret_d       = ret_q + 1'b1;
    end

    if (squash) begin
      for (int i = 0; i < SQ_SZ; i++)
        if (st_d[i] == S_ALLOC || st_d[i] == S_RESOLVED) st_d[i] = S_FREE;
      tail_d = ret_d;
    end

    if (drain_go) begin
      st_d[head_q] = S_FREE;
      head_d       = head_q + 1'b1;
    end

    if (alloc_go) begin
      st_d[tail_q] = S_ALLOC;
      tail_d       = tail_q + 1'b1;
    end

    for (int i = 0; i < SQ_SZ; i++) n_ret = n_ret + CW'(st_d[i] == S_RETIRED);
    count_d = squash ? n_ret : count_q + CW'(alloc_go) - CW'(drain_go);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SQ_SZ; i++) begin
        st_q[i]   <= S_FREE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        bm_q[i]   <= '0;
      end
      head_q  <= '0;
      ret_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < SQ_SZ; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
        bm_q[i]   <= bm_d[i];
      end
      head_q  <= head_d;
      ret_q   <= ret_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
